// File: rtl/dsp_mac_sequencer_if.sv
// Handshake and control bundle between the operand source and dsp_mac_sequencer.
// The abort signal exists only when DSP_SEQ_ABORT_EN is defined.
interface dsp_mac_sequencer_if #(
  parameter int unsigned LEN_WIDTH = 8,
  parameter int unsigned AB_STAGES = 1,
  parameter int unsigned MREG      = 1
);
  localparam int unsigned L = AB_STAGES + MREG + 1;

  logic                 start;
  logic [LEN_WIDTH-1:0] len;
  logic                 in_valid;
  logic                 in_ready;
  logic [L-1:0]         ce_pipe;
  logic                 rst_p;
  logic [7:0]           opmode;
  logic                 busy;
  logic                 done;
`ifdef DSP_SEQ_ABORT_EN
  logic                 abort;

  modport master (
    output start, len, in_valid, abort,
    input  in_ready, ce_pipe, rst_p, opmode, busy, done
  );
  modport slave (
    input  start, len, in_valid, abort,
    output in_ready, ce_pipe, rst_p, opmode, busy, done
  );
`else
  modport master (
    output start, len, in_valid,
    input  in_ready, ce_pipe, rst_p, opmode, busy, done
  );
  modport slave (
    input  start, len, in_valid,
    output in_ready, ce_pipe, rst_p, opmode, busy, done
  );
`endif
endinterface

// File: rtl/dsp_mac_sequencer.sv
// Clock-enable / OPMODE sequencer for a DSP48A1 multiply-accumulate pipeline.
// Optional DSP_SEQ_ABORT_EN adds an abort input that cancels a running job.
module dsp_mac_sequencer #(
  parameter int unsigned LEN_WIDTH = 8,
  parameter int unsigned AB_STAGES = 1,
  parameter int unsigned MREG      = 1
) (
  input logic               clk,
  input logic               rst,
  dsp_mac_sequencer_if.slave bus
);
  localparam int unsigned L = AB_STAGES + MREG + 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFeed  = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  // Token bit j marks a real pair sitting in stage j, so it enables stage j+1.
  logic [L-2:0]         tok_q, tok_d;
  logic [L-2:0]         fst_q, fst_d;
  logic                 first_q, first_d;
  logic                 accept;
  logic                 abort_hit;
  logic                 rst_p_c;

  assign bus.in_ready = (state_q == StFeed);
  assign accept       = bus.in_valid && bus.in_ready;

`ifdef DSP_SEQ_ABORT_EN
  assign abort_hit = bus.abort && ((state_q == StFeed) || (state_q == StDrain));
`else
  assign abort_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    tok_d   = (L-1)'({tok_q, accept});
    fst_d   = (L-1)'({fst_q, accept && first_q});
    rst_p_c = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (bus.len == '0) begin
            state_d = StDone;
            rst_p_c = 1'b1;
          end else begin
            state_d = StFeed;
            cnt_d   = bus.len;
            first_d = 1'b1;
          end
        end
      end
      StFeed: begin
        if (accept) begin
          cnt_d   = cnt_q - LEN_WIDTH'(1);
          first_d = 1'b0;
          if (cnt_q == LEN_WIDTH'(1)) state_d = StDrain;
        end
      end
      StDrain: begin
        // Leave once only the P-stage enable remains, so done lands after P captures.
        if (tok_d == '0) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (abort_hit) begin
      state_d = StIdle;
      cnt_d   = '0;
      first_d = 1'b0;
      tok_d   = '0;
      fst_d   = '0;
      rst_p_c = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      tok_q   <= '0;
      fst_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tok_q   <= tok_d;
      fst_q   <= fst_d;
      first_q <= first_d;
    end
  end

  assign bus.ce_pipe = {tok_q, accept};
  assign bus.opmode  = tok_q[L-2] ? (fst_q[L-2] ? 8'h01 : 8'h09) : 8'h00;
  assign bus.rst_p   = rst_p_c && !rst;
  assign bus.busy    = (state_q != StIdle);
  assign bus.done    = (state_q == StDone);
endmodule

// File: doc/dsp_mac_sequencer.md
# dsp_mac_sequencer

Control sequencer for the DSP48A1 slice's pipelined multiply-accumulate path. It accepts a job of N operand pairs over a valid/ready handshake. It tracks every accepted pair through the A/B, M and P pipeline registers, driving one clock enable per stage plus the OPMODE word at the P stage, so the first product loads P and later products accumulate into P. It reports completion when the last product has landed in P. It sits between the operand source and the slice's register/mux stages; it never touches operand data, only enables and opmode.

## Interface
- `LEN_WIDTH`, 8, width of the job length / pair counter.
- `AB_STAGES`, 1, number of enabled A/B input register stages; legal values are 1 or 2.
- `MREG`, 1, M register present; legal values are 0 or 1.
- Derived: `L = AB_STAGES + MREG + 1` is the pipeline depth. The P register is always present.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: job launch, sampled only in IDLE.
- `len` in LEN_WIDTH: number of pairs N, sampled with `start`.
- `in_valid` in 1: the source presents an operand pair to the slice inputs.
- `in_ready` out 1: the sequencer accepts the pair this cycle.
- `ce_pipe` out L: bit k enables pipeline stage k. Bit 0 is the first A/B register and bit L-1 is P.
- `rst_p` out 1: one-cycle synchronous clear for the P register.
- `opmode` out 8: slice OPMODE, meaningful when `ce_pipe[L-1]`=1.
- `busy` out 1: a job is in progress.
- `done` out 1: one-cycle pulse; P holds the final sum.
- `abort` in 1: present only with `DSP_SEQ_ABORT_EN`.

## Operation
- FSM states: IDLE, FEED, DRAIN, DONE.
- IDLE → FEED on `start` with `len`≠0. The count is loaded with `len`.
- IDLE → DONE on `start` with `len`=0. `rst_p` is pulsed in that same transition cycle, so the result is P=0.
- FEED:
  - `in_ready` = 1.
  - An accept (`in_valid && in_ready`) decrements the count.
  - The accept of the last pair moves to DRAIN.
- DRAIN: `in_ready` = 0. Wait until the token vector is empty, then go to DONE.
- DONE: `done` = 1 for one cycle, then IDLE.
- Token vector `tok[L-1:0]`:
  - Every cycle, `tok <= {tok[L-2:0], accept}`.
  - `ce_pipe[0] = accept`; `ce_pipe[k] = tok[k-1]` for k ≥ 1.
  - Pipeline stages advance only for real pairs, so bubbles in `in_valid` do not corrupt the sum.
- A parallel first-flag shift register marks the job's first pair. When that pair reaches P:
  - `opmode = 8'h01` (X=M, Z=0).
  - Every later pair: `opmode = 8'h09` (X=M, Z=P).
  - With no P-stage token: `opmode = 8'h00`.
- `busy` is 1 in FEED, DRAIN and DONE.
- `start` is ignored while `busy` is 1.
- `rst` is honoured in any state, including mid-FEED and mid-DRAIN. It returns the block to IDLE, clears the count, tokens and flags, and produces no `done`.
- Reset value of all outputs is 0, including `opmode`=8'h00 and `ce_pipe`=0.

## Timing
- A pair accepted in cycle t:
  - Enables stage k during cycle t+k.
  - P captures its sum at the edge closing cycle t+L-1.
- If the last pair is accepted in cycle t, then `done` = 1 in cycle t+L.
- `len`=0 case: `start` in cycle t gives `rst_p` in cycle t and `done` in cycle t+1.
- `in_ready` is registered from the state only, with no combinational path from `in_valid`.
- Back-to-back jobs: `start` may be asserted in the cycle after `done`, when the block is in IDLE. Minimum job period is N+L+1 cycles.
- Full-range N = 2^LEN_WIDTH−1 must complete without counter wrap.

## Configuration
- `DSP_SEQ_ABORT_EN`:
  - Defined: adds the `abort` input.
  - `abort` in FEED or DRAIN forces IDLE next cycle, clears tokens, pulses `rst_p` for one cycle, and suppresses `done`.
  - `abort` in IDLE or DONE is ignored.
  - `abort` coincident with `rst`: `rst` wins, and `rst_p` is not pulsed.
- Undefined: the port does not exist, and jobs run only to completion or `rst`.

## Test plan
- N=3, L=3, `in_valid` held high:
  - Accepts in cycles 1–3.
  - `ce_pipe[2]` high in cycles 3–5, with `opmode` 01, 09, 09.
  - `done` in cycle 6.
  - P equals the sum of the three products.
- N=4 with `in_valid` low every other cycle:
  - Each `ce_pipe` bit pulses only for real pairs.
  - `done` = 1 exactly L cycles after the 4th accept.
  - Sum is correct.
- `len`=0: `rst_p` in the `start` cycle, `done` the next cycle, no `ce_pipe` activity, P=0.
- `start` pulsed during DRAIN of an N=2 job: ignored, and exactly one `done`.
- `rst` asserted two cycles into FEED of an N=5 job: next cycle all outputs are 0, `busy`=0, no `done`. A following N=1 job behaves normally.
- With `DSP_SEQ_ABORT_EN`, `abort` in DRAIN: `rst_p` pulses once, `busy` drops next cycle, and `done` never asserts.
